// File: rtl/serial_word_transmitter.sv
// rtl/serial_word_transmitter.sv - multi-byte UART-style word transmitter
//
// Sends WORD_BYTES bytes as back-to-back frames: start bit, 8 data bits
// LSB-first, optional parity bit, STOP_BITS stop bits. Each bit lasts
// CLKS_PER_BIT clocks. A transfer is triggered by a rising edge on start
// while idle.
//
// Optional feature macro: SERIAL_TX_PARITY_EN (inserts a parity bit after
// data bit 7 of every byte; PARITY_ODD selects odd parity).
//
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   word_in - word to send, sampled on the trigger edge
//   start   - request; rising edge starts a transfer
//   tx      - serial line, idles high
//   ready   - high when idle and able to accept a trigger
//   done    - one-cycle pulse when the last stop bit has completed

`timescale 1ns/1ps

module serial_word_transmitter #(
    parameter int WORD_BYTES     = 4,
    parameter int CLKS_PER_BIT   = 1,
    parameter int STOP_BITS      = 1,
    parameter int MSB_BYTE_FIRST = 0,
    parameter int PARITY_ODD     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    start,
    output logic                    tx,
    output logic                    ready,
    output logic                    done
);

    localparam int DIV_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(WORD_BYTES - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
    localparam bit                PARITY_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [2:0]              bit_idx;
    logic [STOP_W-1:0]       stop_cnt;
    logic [BYTE_W-1:0]       byte_idx;
    logic [8*WORD_BYTES-1:0] word_q;
    logic                    start_q;

    logic [BYTE_W-1:0]       byte_sel;
    logic [7:0]              cur_byte;
    logic                    bit_end;
    logic                    trigger;

    // Byte order is resolved here so the FSM always walks byte_idx upward.
    always_comb begin
        byte_sel = byte_idx;
        if (MSB_BYTE_FIRST != 0) begin
            byte_sel = BYTE_LAST - byte_idx;
        end
    end

    assign cur_byte = word_q[{byte_sel, 3'b000} +: 8];
    assign bit_end  = (div_cnt == DIV_LAST);
    assign trigger  = start & ~start_q;

`ifdef SERIAL_TX_PARITY_EN
    logic parity_bit;
    assign parity_bit = (^cur_byte) ^ PARITY_SENSE;
`else
    logic unused_parity_sense;
    assign unused_parity_sense = PARITY_SENSE;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            byte_idx <= '0;
            word_q   <= '0;
            // History starts high so a start held through reset release
            // is not seen as an edge.
            start_q  <= 1'b1;
            tx       <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    ready    <= 1'b1;
                    div_cnt  <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= '0;
                    byte_idx <= '0;
                    if (trigger) begin
                        word_q <= word_in;
                        tx     <= 1'b0;
                        ready  <= 1'b0;
                        state  <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx       <= 1'b1;
                            stop_cnt <= '0;
                            state    <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        div_cnt  <= '0;
                        tx       <= 1'b1;
                        stop_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= '0;
                            if (byte_idx == BYTE_LAST) begin
                                tx    <= 1'b1;
                                ready <= 1'b1;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                // Next start bit follows the stop bit directly.
                                byte_idx <= byte_idx + BYTE_W'(1);
                                tx       <= 1'b0;
                                state    <= START;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + STOP_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    div_cnt  <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= '0;
                    byte_idx <= '0;
                    tx       <= 1'b1;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule
